// File: rtl/ocra1_pkg.sv
// Shared types for the OCRA1 DAC serialiser: FSM state encoding, word width, latched frame.
package ocra1_pkg;

  localparam int WORD_W    = 24;
  localparam int BIT_CNT_W = 5;
  localparam int TMR_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    LDAC  = 2'd3
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic [WORD_W-1:0] z;
    logic [WORD_W-1:0] z2;
    logic              ldac;
  } frame_t;

endpackage

// File: rtl/ocra1_spi_clkdiv.sv
// SPI clock generator: idles high, SPI_DIV cycles per half-period, strobes on the last cycle of each half.
// Latency: level changes one cycle after a strobe; no backpressure, held idle while en=0.
module ocra1_spi_clkdiv #(
  parameter int SPI_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic spi_clk,
  output logic spi_rise,
  output logic spi_fall
);

  localparam logic [3:0] DIV_LAST = 4'(SPI_DIV - 1);

  logic [3:0] div_cnt;
  logic       half_end;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt <= '0;
      spi_clk <= 1'b1;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      spi_clk <= ~spi_clk;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // Strobes announce the edge that appears on spi_clk in the following cycle.
  assign half_end = en && (div_cnt == DIV_LAST);
  assign spi_rise = half_end && !spi_clk;
  assign spi_fall = half_end &&  spi_clk;

endmodule

// File: rtl/ocra1_serialiser.sv
// Four-channel lockstep SPI serialiser for the OCRA1 DACs with optional LDAC pulse; busy_o high one cycle after accept,
// new requests ignored while busy. Optional sticky overrun flag err_o under OCRA1_SERIALISER_ERR_EN.
module ocra1_serialiser
  import ocra1_pkg::*;
#(
  parameter int SPI_DIV  = 2,
  parameter int LDAC_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] data_x_i,
  input  logic [WORD_W-1:0] data_y_i,
  input  logic [WORD_W-1:0] data_z_i,
  input  logic [WORD_W-1:0] data_z2_i,
  input  logic              valid_i,
  input  logic              ldac_i,
  output logic              busy_o,
  output logic              oc1_clk_o,
  output logic              oc1_syncn_o,
  output logic              oc1_ldacn_o,
  output logic              oc1_sdox_o,
  output logic              oc1_sdoy_o,
  output logic              oc1_sdoz_o,
  output logic              oc1_sdoz2_o
`ifdef OCRA1_SERIALISER_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam logic [TMR_W-1:0]     GAP_LAST  = TMR_W'(2 * SPI_DIV - 1);
  localparam logic [TMR_W-1:0]     LDAC_LAST = TMR_W'(LDAC_LEN - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_MSB   = BIT_CNT_W'(WORD_W - 1);

  state_t                state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  frame_t                frame_q, frame_d;
  logic                  clocked_q, clocked_d;
  logic                  spi_clk, spi_rise, spi_fall;
  logic                  shifting;

  assign shifting = (state_q == SHIFT);

  ocra1_spi_clkdiv #(
    .SPI_DIV (SPI_DIV)
  ) u_clkdiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (shifting),
    .spi_clk  (spi_clk),
    .spi_rise (spi_rise),
    .spi_fall (spi_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tmr_q     <= '0;
      frame_q   <= '0;
      clocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmr_q     <= tmr_d;
      frame_q   <= frame_d;
      clocked_q <= clocked_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmr_d     = tmr_q;
    frame_d   = frame_q;
    clocked_d = clocked_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d   = SHIFT;
          bit_cnt_d = BIT_MSB;
          tmr_d     = '0;
          clocked_d = 1'b0;
          frame_d   = '{x: data_x_i, y: data_y_i, z: data_z_i, z2: data_z2_i, ldac: ldac_i};
        end
      end
      SHIFT: begin
        // clocked_q records that the DAC has seen the falling edge of the current bit.
        if (spi_fall) clocked_d = 1'b1;
        if (spi_rise && clocked_q) begin
          clocked_d = 1'b0;
          if (bit_cnt_q == '0) state_d = GAP;
          else                 bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = frame_q.ldac ? LDAC : IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      LDAC: begin
        if (tmr_q == LDAC_LAST) begin
          tmr_d   = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign oc1_clk_o   = spi_clk;
  assign oc1_syncn_o = !shifting;
  assign oc1_ldacn_o = (state_q != LDAC);
  assign oc1_sdox_o  = shifting && frame_q.x[bit_cnt_q];
  assign oc1_sdoy_o  = shifting && frame_q.y[bit_cnt_q];
  assign oc1_sdoz_o  = shifting && frame_q.z[bit_cnt_q];
  assign oc1_sdoz2_o = shifting && frame_q.z2[bit_cnt_q];

`ifdef OCRA1_SERIALISER_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                err_o <= 1'b0;
    else if (valid_i && busy_o) err_o <= 1'b1;
  end
`endif

endmodule
